// File: rtl/corefifo_pkg.sv
// corefifo_pkg: shared constants and Gray/binary helpers for the FIFO core.
// Helpers take an explicit bit width so every pointer size shares one body.
package corefifo_pkg;

  localparam int BUF_DEPTH = 2;
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);

  typedef logic [OCC_W-1:0] occ_t;

  function automatic logic [31:0] width_mask(input int w);
    logic [31:0] m;
    if (w >= 32) m = '1;
    else m = (32'd1 << w) - 32'd1;
    return m;
  endfunction

  // bit i of the binary value is the XOR of Gray bits i and above
  function automatic logic [31:0] gray2bin(
    input logic [31:0] g,
    input int          w
  );
    logic [31:0] b;
    b = g & width_mask(w);
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i] ^ b[i+1];
    end
    return b;
  endfunction

  function automatic logic [31:0] bin2gray(
    input logic [31:0] b,
    input int          w
  );
    logic [31:0] v;
    v = b & width_mask(w);
    return v ^ (v >> 1);
  endfunction

endpackage

// File: rtl/corefifo_rd_prefetch.sv
// corefifo_rd_prefetch: 2-entry head/skid first-word-fall-through buffer.
// Ports: clk, srst, arrival+rdata (RAM word landing), pop -> dout, valid, occ.
module corefifo_rd_prefetch
  import corefifo_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              arrival,
  input  logic [DWIDTH-1:0] rdata,
  input  logic              pop,
  output logic [DWIDTH-1:0] dout,
  output logic              valid,
  output occ_t              occ
);

  logic [DWIDTH-1:0] head;
  logic [DWIDTH-1:0] skid;
  logic [DWIDTH-1:0] head_d;
  logic              skid_adv;
  logic              arr_head;
  logic              arr_skid;

  assign skid_adv = pop & (occ == occ_t'(BUF_DEPTH));

  // a landing word goes to the head whenever the head is free
  // (or being vacated with nothing behind it); otherwise to the skid
  assign arr_head = arrival &
    ((occ == occ_t'(0)) | ((occ == occ_t'(1)) & pop));
  assign arr_skid = arrival & ~arr_head;

  always_comb begin
    head_d = head;
    unique case (1'b1)
      skid_adv: head_d = skid;
      arr_head: head_d = rdata;
      default:  head_d = head;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      head <= '0;
      skid <= '0;
      occ  <= '0;
    end else begin
      head <= head_d;
      if (arr_skid) skid <= rdata;
      occ <= occ + occ_t'(arrival) - occ_t'(pop);
    end
  end

  assign dout  = head;
  assign valid = (occ != occ_t'(0));

endmodule

// File: rtl/corefifo_rd_ctrl.sv
// corefifo_rd_ctrl: read-domain FIFO controller (pointers, RAM read scheduling, flags).
// Ports: clk, srst, wptr_gray_sync, re, ram_rdata -> ram_re, ram_raddr,
//        rptr_gray, dout, valid, empty, aempty, rdcnt, underflow.
module corefifo_rd_ctrl
  import corefifo_pkg::*;
#(
  parameter int ADDRWIDTH     = 3,
  parameter int DWIDTH        = 8,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic [ADDRWIDTH:0]   wptr_gray_sync,
  input  logic                 re,
  input  logic [DWIDTH-1:0]    ram_rdata,
  output logic                 ram_re,
  output logic [ADDRWIDTH-1:0] ram_raddr,
  output logic [ADDRWIDTH:0]   rptr_gray,
  output logic [DWIDTH-1:0]    dout,
  output logic                 valid,
  output logic                 empty,
  output logic                 aempty,
  output logic [ADDRWIDTH:0]   rdcnt,
  output logic                 underflow
);

  localparam int PW = ADDRWIDTH + 1;
  localparam int FW = OCC_W + 1;

  logic [PW-1:0] wbin_r;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] cnt_now;
  logic [FW-1:0] fill;
  logic          inflight;
  logic          ram_avail;
  logic          pop;
  occ_t          occ;

  assign pop       = re & valid;
  assign ram_avail = (wbin_r != rbin);
  assign fill      = {1'b0, occ} + FW'(inflight);

  // a pop frees a slot this cycle, so a read may be issued into it
  assign ram_re = ~srst & ram_avail &
    ((fill < FW'(BUF_DEPTH)) | pop);

  assign rbin_next = rbin + PW'(ram_re);
  assign ram_raddr = rbin[ADDRWIDTH-1:0];

  assign cnt_now = (wbin_r - rbin) + PW'(inflight) + PW'(occ);

  always_ff @(posedge clk) begin
    if (srst) begin
      wbin_r    <= '0;
      rbin      <= '0;
      rptr_gray <= '0;
      inflight  <= 1'b0;
      rdcnt     <= '0;
      aempty    <= 1'b1;
      underflow <= 1'b0;
    end else begin
      wbin_r    <= PW'(gray2bin(32'(wptr_gray_sync), PW));
      rbin      <= rbin_next;
      rptr_gray <= PW'(bin2gray(32'(rbin_next), PW));
      inflight  <= ram_re;
      rdcnt     <= cnt_now;
      aempty    <= (32'(cnt_now) <= 32'(AEMPTY_THRESH));
      underflow <= re & ~valid;
    end
  end

  corefifo_rd_prefetch #(
    .DWIDTH (DWIDTH)
  ) u_prefetch (
    .clk     (clk),
    .srst    (srst),
    .arrival (inflight),
    .rdata   (ram_rdata),
    .pop     (pop),
    .dout    (dout),
    .valid   (valid),
    .occ     (occ)
  );

  assign empty = ~valid;

endmodule
